// File: rtl/sub_arbiter_if.sv
// Bundle of the arbiter's requester-side and subtractor-side signals.
// The slave modport is the arbiter itself; master is the surrounding logic.
interface sub_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 16
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] op_a;
    logic [N_REQ*W-1:0] op_b;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       sub_a;
    logic [W-1:0]       sub_b;
    logic [W-1:0]       sub_s;
    logic [W-1:0]       res;
    logic               res_ovf;
    logic [1:0]         res_id;
    logic               res_valid;
    logic               busy;

    modport slave (
        input  req, op_a, op_b, sub_s,
        output gnt, sub_a, sub_b, res, res_ovf, res_id, res_valid, busy
    );

    modport master (
        output req, op_a, op_b, sub_s,
        input  gnt, sub_a, sub_b, res, res_ovf, res_id, res_valid, busy
    );
endinterface

// File: rtl/sub_arbiter.sv
// Round-robin scheduler sharing one 16-bit subtractor (s = b - a) among four
// requesters; returns the result with a signed-overflow flag and requester ID.
module sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    sub_arbiter_if.slave bus
);
    localparam int IDW = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t           state_reg;
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [W-1:0]     sub_a_reg;
    logic [W-1:0]     sub_b_reg;
    logic [W-1:0]     res_reg;
    logic             res_ovf_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             res_valid_reg;
    logic             busy_reg;

    logic [W-1:0]     op_a_arr [N_REQ];
    logic [W-1:0]     op_b_arr [N_REQ];
    logic [N_REQ-1:0] req_rot;
    logic [IDW-1:0]   win_next;
    logic             win_valid;
    logic             ovf_next;

    // req_rot[k] is the request k places after the pointer, so the lowest
    // set bit of req_rot is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a_arr[gi] = bus.op_a[gi*W +: W];
            assign op_b_arr[gi] = bus.op_b[gi*W +: W];
            assign req_rot[gi]  = bus.req[IDW'(gi) + ptr_reg];
        end
    endgenerate

    always_comb begin
        win_valid = 1'b0;
        win_next  = ptr_reg;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_valid = 1'b1;
                win_next  = ptr_reg + IDW'(i);
            end
        end
    end

    // Overflow when operands differ in sign and the result's sign differs from b.
    assign ovf_next = (sub_a_reg[W-1] ^ sub_b_reg[W-1]) & (bus.sub_s[W-1] ^ sub_b_reg[W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            gnt_reg       <= '0;
            sub_a_reg     <= '0;
            sub_b_reg     <= '0;
            res_reg       <= '0;
            res_ovf_reg   <= 1'b0;
            res_id_reg    <= '0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            gnt_reg       <= '0;
            res_valid_reg <= 1'b0;
            case (state_reg)
                ISSUE: begin
                    res_reg       <= bus.sub_s;
                    res_ovf_reg   <= ovf_next;
                    res_id_reg    <= id_reg;
                    res_valid_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                    state_reg     <= CAPTURE;
                end
                default: begin
                    if (win_valid) begin
                        sub_a_reg <= op_a_arr[win_next];
                        sub_b_reg <= op_b_arr[win_next];
                        id_reg    <= win_next;
                        gnt_reg   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_next;
                        ptr_reg   <= win_next + 2'd1;
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.sub_a     = sub_a_reg;
    assign bus.sub_b     = sub_b_reg;
    assign bus.res       = res_reg;
    assign bus.res_ovf   = res_ovf_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_sub_arbiter.sv
// Randomized and directed bench for sub_arbiter against a cycle-level
// round-robin scoreboard built from integer arithmetic.
module tb_sub_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_arbiter_if #(.N_REQ(4), .W(16)) bus ();

    sub_arbiter #(.N_REQ(4), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural stand-in for the shared subtractor.
    assign bus.sub_s = bus.sub_b - bus.sub_a;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard state
    int          m_ptr;
    bit          m_granted_last;
    logic [15:0] m_res;
    bit          m_ovf;
    int          m_id;
    logic [15:0] m_sa, m_sb;
    int          m_pid;
    logic [3:0]  e_gnt;
    bit          e_valid;
    bit          rereq = 1'b0;

    task automatic model_reset();
        m_ptr = 0; m_granted_last = 0; m_res = 0; m_ovf = 0; m_id = 0;
        m_sa = 0; m_sb = 0; m_pid = 0;
    endtask

    // Predict one clock edge from current inputs, advance, then compare.
    task automatic step();
        int diff;
        e_gnt   = 4'b0;
        e_valid = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_granted_last) begin
                e_valid = 1'b1;
                m_res   = m_sb - m_sa;
                diff    = int'($signed(m_sb)) - int'($signed(m_sa));
                m_ovf   = (diff > 32767) || (diff < -32768);
                m_id    = m_pid;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    if (e_gnt == 4'b0 && bus.req[idx]) begin
                        e_gnt[idx] = 1'b1;
                        m_sa  = bus.op_a[idx*16 +: 16];
                        m_sb  = bus.op_b[idx*16 +: 16];
                        m_pid = idx;
                        m_ptr = (idx + 1) % 4;
                    end
                end
            end
            m_granted_last = (e_gnt != 4'b0);
        end
        @(posedge clk);
        #1;
        check("gnt",       32'(bus.gnt),       32'(e_gnt));
        check("res_valid", 32'(bus.res_valid), 32'(e_valid));
        check("busy",      32'(bus.busy),      32'((e_gnt != 4'b0) || e_valid));
        check("res",       32'(bus.res),       32'(m_res));
        check("res_ovf",   32'(bus.res_ovf),   32'(m_ovf));
        check("res_id",    32'(bus.res_id),    32'(m_id));
        check("sub_a",     32'(bus.sub_a),     32'(m_sa));
        check("sub_b",     32'(bus.sub_b),     32'(m_sb));
        // Requester behaviour after seeing its grant
        for (int i = 0; i < 4; i++) begin
            if (e_gnt[i]) begin
                if (rereq) begin
                    bus.op_a[i*16 +: 16] = 16'($urandom);
                    bus.op_b[i*16 +: 16] = 16'($urandom);
                end else begin
                    bus.req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic post(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req[i]           = 1'b1;
        bus.op_a[i*16 +: 16] = a;
        bus.op_b[i*16 +: 16] = b;
    endtask

    task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input bit exp_ovf);
        post(i, a, b);
        step();
        step();
        check("dir_res", 32'(bus.res), 32'(exp_res));
        check("dir_ovf", 32'(bus.res_ovf), 32'(exp_ovf));
        check("dir_id",  32'(bus.res_id), 32'(i));
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        model_reset();
        step();
        step();
        rst = 1'b0;

        // Single request with latency check
        post(2, 16'd5, 16'd12);
        step();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        step();
        check("single_valid", 32'(bus.res_valid), 32'h1);
        check("single_res", 32'(bus.res), 32'd7);
        check("single_id", 32'(bus.res_id), 32'd2);
        step();

        // Wrap / signed overflow
        run_one(0, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
        run_one(1, 16'h0001, 16'h8000, 16'h7FFF, 1'b1);
        run_one(3, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1);

        // Fairness: all four held, grants rotate 0,1,2,3,0
        do_reset();
        rereq = 1'b1;
        for (int i = 0; i < 4; i++) post(i, 16'($urandom), 16'($urandom));
        for (int n = 0; n < 5; n++) begin
            step();
            check("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << (n % 4)));
            step();
            check("fair_id", 32'(bus.res_id), 32'(n % 4));
        end
        rereq = 1'b0;
        bus.req = '0;
        step();
        step();

        // Pointer rotation after serving requester 3
        do_reset();
        run_one(3, 16'd1, 16'd2, 16'd1, 1'b0);
        post(0, 16'd10, 16'd30);
        post(1, 16'd20, 16'd25);
        step();
        check("rot_first", 32'(bus.gnt), 32'h1);
        step();
        step();
        check("rot_second", 32'(bus.gnt), 32'h2);
        step();
        step();

        // Reset during ISSUE discards the operation
        post(1, 16'd3, 16'd9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ptr_res", 32'(bus.res), 32'd0);
        bus.req = '0;
        step();
        check("rst_no_valid", 32'(bus.res_valid), 32'd0);
        post(1, 16'd4, 16'd14);
        step();
        check("rst_regnt", 32'(bus.gnt), 32'h2);
        step();
        check("rst_res", 32'(bus.res), 32'd10);

        // Idle hold
        for (int n = 0; n < 10; n++) step();
        check("idle_res", 32'(bus.res), 32'd10);
        check("idle_id", 32'(bus.res_id), 32'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rereq = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] && $urandom_range(0, 2) == 0)
                    post(i, 16'($urandom), 16'($urandom));
            end
            if ($urandom_range(0, 150) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
